// File: rtl/maj3_pipe.sv
// maj3_pipe: bitwise 3-input majority with per-operand inversion, behind a
// valid/ready output register plus one skid entry. Optional transfer counter: MAJ3_PIPE_CNT_EN.
module maj3_pipe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [2:0]       inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef MAJ3_PIPE_CNT_EN
  ,
  output logic [31:0]      xfer_cnt
`endif
);

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] x0,
                                            input logic [WIDTH-1:0] x1,
                                            input logic [WIDTH-1:0] x2);
    return (x0 & x1) | (x0 & x2) | (x1 & x2);
  endfunction

  logic [WIDTH-1:0] a_eff_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] c_eff_s;
  logic [WIDTH-1:0] res_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  logic             out_valid_r;
  logic             skid_full_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] skid_r;

  // operand conditioning and per-bit vote
  always_comb begin
    a_eff_s = a ^ {WIDTH{inv[0]}};
    b_eff_s = b ^ {WIDTH{inv[1]}};
    c_eff_s = c ^ {WIDTH{inv[2]}};
    res_s   = maj3(a_eff_s, b_eff_s, c_eff_s);
  end

  // in_ready comes only from registered state so out_ready never reaches it
  assign in_ready   = rst_n & ~skid_full_r;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid_r & out_ready;

  // output register and skid entry; accepted results leave in order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      skid_full_r <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
    end else begin
      case ({out_xfer_s, in_xfer_s})
        2'b10: begin
          if (skid_full_r) begin
            y_r         <= skid_r;
            skid_full_r <= 1'b0;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        // in_xfer implies skid empty, so the new result goes straight to y
        2'b11: begin
          y_r         <= res_s;
          out_valid_r <= 1'b1;
        end
        2'b01: begin
          if (out_valid_r) begin
            skid_r      <= res_s;
            skid_full_r <= 1'b1;
          end else begin
            y_r         <= res_s;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign y         = y_r;

`ifdef MAJ3_PIPE_CNT_EN
  logic [31:0] xfer_cnt_r;

  // output transfer counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_r <= 32'd0;
    end else if (out_xfer_s) begin
      xfer_cnt_r <= xfer_cnt_r + 32'd1;
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_maj3_pipe.sv
// Self-checking bench for maj3_pipe (WIDTH=4): scoreboard of expected results
// pushed on input transfers, compared against captured output transfers.
module tb_maj3_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [2:0] inv;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
`ifdef MAJ3_PIPE_CNT_EN
  logic [31:0] xfer_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  maj3_pipe #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .inv(inv),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef MAJ3_PIPE_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count effective ones per bit, majority means two or more
  function automatic logic [3:0] model(input logic [3:0] ta, input logic [3:0] tb_,
                                       input logic [3:0] tc, input logic [2:0] ti);
    logic [3:0] r;
    int n;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      if ((ta[i] ^ ti[0]) == 1'b1) n++;
      if ((tb_[i] ^ ti[1]) == 1'b1) n++;
      if ((tc[i] ^ ti[2]) == 1'b1) n++;
      r[i] = (n >= 2);
    end
    return r;
  endfunction

  // One clock cycle, called and returning at a negedge; records transfers.
  task automatic drive_cycle(input logic iv, input logic [3:0] ta, input logic [3:0] tb_,
                             input logic [3:0] tc, input logic [2:0] ti,
                             input logic ordy, output logic acc);
    in_valid = iv; a = ta; b = tb_; c = tc; inv = ti; out_ready = ordy;
    #1;
    acc = iv && (in_ready === 1'b1) && rst_n;
    if (acc) exp_q.push_back(model(ta, tb_, tc, ti));
    if (rst_n && out_valid === 1'b1 && ordy) got_q.push_back(y);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 20 && out_valid === 1'b1; k++)
      drive_cycle(1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 1'b1, acc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 4'hF; b = 4'hF; c = 4'hF; inv = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 4'h0) begin errors++; $display("FAIL reset_y: got %h expected 0", y); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_release: got %b expected 1", in_ready); end
`ifdef MAJ3_PIPE_CNT_EN
    checks++; if (xfer_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt); end
`endif
    @(negedge clk);
  endtask

  task automatic test_truth_table();
    logic acc;
    logic [2:0] t;
    logic [3:0] e;
    for (int i = 0; i < 8; i++) begin
      t = 3'(i);
      e = ((int'(t[0]) + int'(t[1]) + int'(t[2])) >= 2) ? 4'hF : 4'h0;
      drive_cycle(1'b1, {4{t[0]}}, {4{t[1]}}, {4{t[2]}}, 3'b000, 1'b1, acc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tt_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (y !== e) begin errors++; $display("FAIL tt_y[%0d]: got %h expected %h", i, y, e); end
    end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tt_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL tt_order: got %h expected %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_width4_inv();
    logic acc;
    drive_cycle(1'b1, 4'b1100, 4'b1010, 4'b0110, 3'b000, 1'b1, acc);
    checks++; if (y !== 4'b1110) begin errors++; $display("FAIL w4_noinv: got %b expected 1110", y); end
    drive_cycle(1'b1, 4'b1100, 4'b1010, 4'b0110, 3'b001, 1'b1, acc);
    checks++; if (y !== 4'b0010) begin errors++; $display("FAIL w4_inva: got %b expected 0010", y); end
    drain();
    got_q.delete(); exp_q.delete();
  endtask

  // Bits 3/2 carry A=1,B=1 and A=1,B=0 cases of the MAJ+NOT half adder
  task automatic test_half_adder();
    logic acc;
    drive_cycle(1'b1, 4'b1100, 4'b1010, 4'b0000, 3'b000, 1'b1, acc);
    checks++; if (y !== 4'b1000) begin errors++; $display("FAIL ha_m1_cout: got %b expected 1000", y); end
    drive_cycle(1'b1, 4'b1100, 4'b1010, 4'b1111, 3'b000, 1'b1, acc);
    checks++; if (y !== 4'b1110) begin errors++; $display("FAIL ha_m2: got %b expected 1110", y); end
    drive_cycle(1'b1, 4'b1110, 4'b1000, 4'b0000, 3'b010, 1'b1, acc);
    checks++; if (y !== 4'b0110) begin errors++; $display("FAIL ha_sum: got %b expected 0110", y); end
    drain();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [3:0] da[5], db[5], dc[5];
    logic [2:0] di[5];
    logic [3:0] first;
    int idx;
    for (int i = 0; i < 5; i++) begin
      da[i] = 4'($urandom); db[i] = 4'($urandom); dc[i] = 4'($urandom); di[i] = 3'($urandom);
    end
    first = model(da[0], db[0], dc[0], di[0]);
    drive_cycle(1'b1, da[0], db[0], dc[0], di[0], 1'b0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_acc0: got %b expected 1", acc); end
    drive_cycle(1'b1, da[1], db[1], dc[1], di[1], 1'b0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_acc1: got %b expected 1", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_fall: got %b expected 0", in_ready); end
    drive_cycle(1'b1, da[2], db[2], dc[2], di[2], 1'b0, acc);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL bp_acc2_blocked: got %b expected 0", acc); end
    checks++; if (y !== first || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got %h/%b expected %h/1", y, out_valid, first); end
    idx = 2;
    for (int k = 0; k < 30 && idx < 5; k++) begin
      drive_cycle(1'b1, da[idx], db[idx], dc[idx], di[idx], 1'b1, acc);
      if (acc) idx++;
    end
    checks++; if (idx != 5) begin errors++; $display("FAIL bp_accept_timeout: got %0d expected 5", idx); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_timeout: got %b expected 0", out_valid); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < 5 && got_q.size() > 0; i++) begin
      checks++; if (got_q[0] !== model(da[i], db[i], dc[i], di[i])) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_q[0], model(da[i], db[i], dc[i], di[i])); end
      void'(got_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic acc;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), 1'b1, acc);
      checks++; if (acc !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_flow[%0d]: got acc=%b valid=%b expected 1/1", i, acc, out_valid); end
    end
    drain();
    checks++; if (got_q.size() != 8 || exp_q.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d/%0d expected 8", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL b2b_order: got %h expected %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic acc;
    drive_cycle(1'b1, 4'hA, 4'hA, 4'h0, 3'b000, 1'b0, acc);
    drive_cycle(1'b1, 4'h5, 4'h5, 4'h0, 3'b000, 1'b0, acc);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got ready=%b valid=%b expected 0/1", in_ready, out_valid); end
    rst_n = 1'b0;
    drive_cycle(1'b1, 4'hF, 4'hF, 4'hF, 3'b000, 1'b1, acc);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 4'h0) begin errors++; $display("FAIL mid_y: got %h expected 0", y); end
`ifdef MAJ3_PIPE_CNT_EN
    checks++; if (xfer_cnt !== 32'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", xfer_cnt); end
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", out_valid); end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef MAJ3_PIPE_CNT_EN
  task automatic test_counter();
    logic acc;
    int idx;
    idx = 0;
    for (int k = 0; k < 300 && got_q.size() < 10; k++) begin
      drive_cycle((idx < 10) && ($urandom_range(0, 1) == 1), 4'($urandom), 4'($urandom),
                  4'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0), acc);
      if (acc) idx++;
    end
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL cnt_timeout: got %0d expected 10", got_q.size()); end
    checks++; if (xfer_cnt !== 32'd10) begin errors++; $display("FAIL cnt_value: got %0d expected 10", xfer_cnt); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL cnt_order: got %h expected %h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 4'h0; b = 4'h0; c = 4'h0; inv = 3'b000;
    test_reset();
    test_truth_table();
    test_width4_inv();
    test_half_adder();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef MAJ3_PIPE_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maj3_pipe.md
# maj3_pipe

Registered, handshaked bitwise 3-input majority unit (Y = AB + AC + BC per bit), with per-operand input inversion. It is the MAJ primitive used by the majority-logic arithmetic submodules (half/full adders built from MAJ + NOT). Tying one operand to 0 or 1 gives AND or OR. The block adds a valid/ready pipeline stage with a skid register so it can sit in clocked datapaths at full throughput.

## Interface
- WIDTH, default 1: bit width of each operand and of the result; legal values are 1 or more.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operand set on a/b/c/inv is valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- inv  input  3  bit0 inverts A, bit1 inverts B, bit2 inverts C before the vote.
- out_valid  output  1  y holds a valid result.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  WIDTH  majority result.
- xfer_cnt  output  32  count of output transfers; present only with MAJ3_PIPE_CNT_EN.

## Operation
- Effective operands are a' = a ^ {WIDTH{inv[0]}}, b' = b ^ {WIDTH{inv[1]}}, c' = c ^ {WIDTH{inv[2]}}.
- Result per bit: y[i] = (a'[i]&b'[i]) | (a'[i]&c'[i]) | (b'[i]&c'[i]). There is no carry or cross-bit interaction.
- An input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Storage is an output register plus one skid register. Results leave in strict acceptance order; none is dropped or duplicated.
- Input transfer when the output register is empty, or is draining this cycle: the result loads the output register.
- Input transfer while the output register is held (out_valid=1, out_ready=0): the result goes to the skid register.
- When the output drains and the skid register is full, the skid content moves to the output register.
- in_ready = rst_n && !skid_full. in_ready depends only on registered state; there is no combinational path from out_ready.
- While out_valid=1 and out_ready=0, y and out_valid stay stable.
- in_valid may be withdrawn freely. a/b/c/inv are sampled only on a transfer.

## Timing
- Reset values: out_valid=0, y=0, skid empty, xfer_cnt=0. in_ready=0 while rst_n=0 and 1 in the first cycle after reset.
- Reset mid-operation discards all held results. The output transfer in the reset cycle is not counted.
- Latency: an input accepted at edge N gives out_valid=1 with y valid after edge N.
- Throughput: one result per cycle while out_ready=1.
- Backpressure: after one stalled cycle in which an input was accepted, in_ready=0 until the output drains.
- Simultaneous input and output transfer with skid empty: the new result replaces y at that edge, and out_valid stays 1.
- Simultaneous output drain and skid full: the skid moves to output and in_ready returns to 1 on the next cycle.

## Configuration
- MAJ3_PIPE_CNT_EN defined: the xfer_cnt port exists. It increments by 1 on every output transfer and wraps from 0xFFFFFFFF to 0. Reset value is 0.
- MAJ3_PIPE_CNT_EN undefined: the port and counter logic are absent. Datapath behaviour is identical.

## Test plan
- WIDTH=1, inv=0, full truth table (eight a/b/c combinations), out_ready=1 -> y=1 exactly when two or more inputs are 1; each result appears one cycle after its input.
- WIDTH=4, a=1100, b=1010, c=0110, inv=000 -> y=1110. Same operands with inv=001 -> y=0010.
- Half-adder pattern, WIDTH=1, A=1, B=1: m1=MAJ(1,1,0)=1; m2=MAJ(1,1,1)=1; then MAJ(m2, ~m1, 0) -> 0, i.e. Sum=0 and Cout=1. Repeat with A=1, B=0 -> Sum=1, Cout=0.
- Backpressure: stream 5 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, y is stable, then all 5 results emerge in order with no loss once out_ready=1.
- Assert rst_n=0 while both registers are full -> next cycle out_valid=0, y=0, xfer_cnt=0; in_ready=1 after release.
- With MAJ3_PIPE_CNT_EN, 10 output transfers with random stalls -> xfer_cnt=10.
